addsub_serial_n: RTL

ADDSUB_SERIAL_N -- requirements
Module: addsub_serial_n

---
 rtl/addsub_serial_n_if.sv | 32 +++
 rtl/addsub_serial_n.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/addsub_serial_n_if.sv
// addsub_serial_n_if
//   Groups the request/result signals of the serial adder/subtractor.
//   Parameter WIDTH: operand/result width in bits.
//   Signals:
//     start, A, B, Add_ctrl      : request (master -> slave)
//     in_ready, done             : handshake status (slave -> master)
//     SUM, C_out, O, Z           : result and flags (slave -> master)
//   Modports: master (requester / bench), slave (the adder).
interface addsub_serial_n_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Add_ctrl;
  logic             in_ready;
  logic             done;
  logic [WIDTH-1:0] SUM;
  logic             C_out;
  logic             O;
  logic             Z;

  modport master (
    output start, A, B, Add_ctrl,
    input  in_ready, done, SUM, C_out, O, Z
  );

  modport slave (
    input  start, A, B, Add_ctrl,
    output in_ready, done, SUM, C_out, O, Z
  );
endinterface

// File: rtl/addsub_serial_n.sv
// addsub_serial_n
//   Chunk-serial two's complement adder/subtractor. Processes CHUNK bits per
//   cycle, LSB chunk first, for N = WIDTH/CHUNK cycles, then presents the
//   result with a one-cycle done pulse.
//   Parameters:
//     WIDTH : operand/result width (multiple of CHUNK, >= 2)
//     CHUNK : bits processed per cycle (>= 1; CHUNK = WIDTH gives latency 1)
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : addsub_serial_n_if.slave (start, A, B, Add_ctrl in;
//             in_ready, done, SUM, C_out, O, Z out)
//   Build option:
//     ADDSUB_SAT_EN : when defined, SUM saturates on signed overflow
//                     (O and C_out still report the raw values).
module addsub_serial_n #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_serial_n_if.slave   bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             load, step, last;

  logic [WIDTH-1:0] a_sh, b_sh, res_r, sum_r;
  logic             sub_r, carry;
  logic             c_out_r, o_r, z_r;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] a_ck, b_ck;
  logic [CHUNK:0]   ck_sum;
  logic             cout, msb_cin;
  logic [WIDTH-1:0] ins, res_nx, sum_fin;

`ifdef ADDSUB_SAT_EN
  logic             a_msb;
`endif

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign last = (cnt == CW'(N - 1));

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // Operands are shifted right each step so the active chunk always sits in
  // the low CHUNK bits; the result is assembled by shifting in from the top.
  always_comb begin
    a_ck    = a_sh[CHUNK-1:0];
    b_ck    = b_sh[CHUNK-1:0] ^ {CHUNK{sub_r}};
    ck_sum  = {1'b0, a_ck} + {1'b0, b_ck} + {{CHUNK{1'b0}}, carry};
    cout    = ck_sum[CHUNK];
    // sum bit = a ^ b ^ cin, so the carry into the top bit is recovered here
    msb_cin = ck_sum[CHUNK-1] ^ a_ck[CHUNK-1] ^ b_ck[CHUNK-1];
    ins     = '0;
    ins[WIDTH-1 -: CHUNK] = ck_sum[CHUNK-1:0];
    res_nx  = (res_r >> CHUNK) | ins;
    sum_fin = res_nx;
`ifdef ADDSUB_SAT_EN
    if (msb_cin ^ cout)
      sum_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_r   <= '0;
      sub_r   <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      o_r     <= 1'b0;
      z_r     <= 1'b0;
    end else if (load) begin
      a_sh  <= bus.A;
      b_sh  <= bus.B;
      sub_r <= bus.Add_ctrl;
      carry <= bus.Add_ctrl;
      cnt   <= '0;
      res_r <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> CHUNK;
      b_sh  <= b_sh >> CHUNK;
      carry <= cout;
      cnt   <= cnt + CW'(1);
      res_r <= res_nx;
      if (last) begin
        sum_r   <= sum_fin;
        c_out_r <= cout;
        o_r     <= msb_cin ^ cout;
        z_r     <= (sum_fin == '0);
      end
    end
  end

`ifdef ADDSUB_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    a_msb <= 1'b0;
    else if (load) a_msb <= bus.A[WIDTH-1];
  end
`endif

  // ---------------- outputs ----------------
  assign bus.SUM      = sum_r;
  assign bus.C_out    = c_out_r;
  assign bus.O        = o_r;
  assign bus.Z        = z_r;
  assign bus.done     = (state == DONE);
  assign bus.in_ready = (state != CALC);

endmodule
